// File: rtl/adder_arbiter.sv
// Two-requester arbiter sharing one 4-bit ripple-carry adder.
// Stage 1 arbitrates and latches the winner's operands, stage 2 registers
// the sum with the owner's ID. Keeps saturating per-requester grant counts.
module adder_arbiter #(
  parameter bit PRIORITY_RR = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [3:0] A0_bus,
  input  logic [3:0] B0_bus,
  input  logic [3:0] A1_bus,
  input  logic [3:0] B1_bus,
  output logic       ack0,
  output logic       ack1,
  output logic       res_valid,
  output logic       res_id,
  output logic [3:0] S_bus,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
);

  localparam int unsigned DW = 4;
  localparam int unsigned CW = 8;
  localparam logic [CW-1:0] CNT_MAX = '1;

  // Bit-serial carry chain; carry-out is dropped so the sum wraps mod 16.
  function automatic logic [DW-1:0] ripple_adder(input logic [DW-1:0] a,
                                                  input logic [DW-1:0] b);
    logic          c;
    logic [DW-1:0] s;
    c = 1'b0;
    s = '0;
    for (int i = 0; i < int'(DW); i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    return s;
  endfunction

  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [DW-1:0] op_a_q, op_a_d;
  logic [DW-1:0] op_b_q, op_b_d;
  logic          st1_valid_q, st1_valid_d;
  logic          st1_id_q, st1_id_d;
  logic          last_q, last_d;
  logic [CW-1:0] gnt_cnt0_q, gnt_cnt0_d;
  logic [CW-1:0] gnt_cnt1_q, gnt_cnt1_d;
  logic          res_valid_q, res_valid_d;
  logic          res_id_q, res_id_d;
  logic [DW-1:0] s_q, s_d;

  logic any_req;
  logic win;

  assign any_req = req0 | req1;

  // Winner select: RR alternates on contention, fixed priority favours req0.
  always_comb begin
    win = 1'b0;
    if (PRIORITY_RR) begin
      if (req0 && req1) win = ~last_q;
      else              win = req1;
    end else begin
      win = ~req0;
    end
  end

  // Stage 1: grant, ack, operand latch and grant counters.
  always_comb begin
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    st1_valid_d = 1'b0;
    st1_id_d    = st1_id_q;
    last_d      = last_q;
    gnt_cnt0_d  = gnt_cnt0_q;
    gnt_cnt1_d  = gnt_cnt1_q;
    if (any_req) begin
      st1_valid_d = 1'b1;
      st1_id_d    = win;
      last_d      = win;
      if (win) begin
        ack1_d = 1'b1;
        op_a_d = A1_bus;
        op_b_d = B1_bus;
        if (gnt_cnt1_q != CNT_MAX) gnt_cnt1_d = gnt_cnt1_q + CW'(1);
      end else begin
        ack0_d = 1'b1;
        op_a_d = A0_bus;
        op_b_d = B0_bus;
        if (gnt_cnt0_q != CNT_MAX) gnt_cnt0_d = gnt_cnt0_q + CW'(1);
      end
    end
  end

  // Stage 2: add and register; the sum holds when no operation is in flight.
  always_comb begin
    res_valid_d = st1_valid_q;
    res_id_d    = st1_id_q;
    s_d         = s_q;
    if (st1_valid_q) s_d = ripple_adder(op_a_q, op_b_q);
  end

  // State registers with synchronous reset; last=1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      st1_valid_q <= 1'b0;
      st1_id_q    <= 1'b0;
      last_q      <= 1'b1;
      gnt_cnt0_q  <= '0;
      gnt_cnt1_q  <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= 1'b0;
      s_q         <= '0;
    end else begin
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      st1_valid_q <= st1_valid_d;
      st1_id_q    <= st1_id_d;
      last_q      <= last_d;
      gnt_cnt0_q  <= gnt_cnt0_d;
      gnt_cnt1_q  <= gnt_cnt1_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      s_q         <= s_d;
    end
  end

  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign S_bus     = s_q;
  assign gnt_cnt0  = gnt_cnt0_q;
  assign gnt_cnt1  = gnt_cnt1_q;

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: round-robin instance driven from a
// vector table, fixed-priority instance and saturation by hand sequences.
module tb_adder_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [3:0] a0, b0, a1, b1;

  logic       rr_ack0, rr_ack1, rr_rv, rr_rid;
  logic [3:0] rr_s;
  logic [7:0] rr_g0, rr_g1;

  logic       fp_ack0, fp_ack1, fp_rv, fp_rid;
  logic [3:0] fp_s;
  logic [7:0] fp_g0, fp_g1;

  int errors = 0;
  int checks = 0;

  adder_arbiter #(.PRIORITY_RR(1'b1)) dut_rr (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .A0_bus(a0), .B0_bus(b0), .A1_bus(a1), .B1_bus(b1),
    .ack0(rr_ack0), .ack1(rr_ack1), .res_valid(rr_rv), .res_id(rr_rid),
    .S_bus(rr_s), .gnt_cnt0(rr_g0), .gnt_cnt1(rr_g1)
  );

  adder_arbiter #(.PRIORITY_RR(1'b0)) dut_fp (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .A0_bus(a0), .B0_bus(b0), .A1_bus(a1), .B1_bus(b1),
    .ack0(fp_ack0), .ack1(fp_ack1), .res_valid(fp_rv), .res_id(fp_rid),
    .S_bus(fp_s), .gnt_cnt0(fp_g0), .gnt_cnt1(fp_g1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       req0;
    logic       req1;
    logic [3:0] a0;
    logic [3:0] b0;
    logic [3:0] a1;
    logic [3:0] b1;
    logic       e_ack0;
    logic       e_ack1;
    logic       e_rv;
    logic       e_rid;
    logic [3:0] e_s;
    logic [7:0] e_g0;
    logic [7:0] e_g1;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  function automatic vec_t mk(int r, int q0, int q1, int xa0, int xb0,
                              int xa1, int xb1, int ea0, int ea1, int erv,
                              int erid, int es, int eg0, int eg1);
    vec_t v;
    v.rst = 1'(r);    v.req0 = 1'(q0);  v.req1 = 1'(q1);
    v.a0 = 4'(xa0);   v.b0 = 4'(xb0);   v.a1 = 4'(xa1);  v.b1 = 4'(xb1);
    v.e_ack0 = 1'(ea0); v.e_ack1 = 1'(ea1); v.e_rv = 1'(erv);
    v.e_rid = 1'(erid); v.e_s = 4'(es); v.e_g0 = 8'(eg0); v.e_g1 = 8'(eg1);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic q0, input logic q1,
                       input logic [3:0] xa0, input logic [3:0] xb0,
                       input logic [3:0] xa1, input logic [3:0] xb1);
    rst = r; req0 = q0; req1 = q1; a0 = xa0; b0 = xb0; a1 = xa1; b1 = xb1;
  endtask

  initial begin
    // Each row: inputs sampled at one edge, outputs expected right after it.
    vecs[0]  = mk(1,1,1, 3,4, 9,8,    0,0,0,0, 0, 0,0);
    vecs[1]  = mk(1,1,1, 3,4, 9,8,    0,0,0,0, 0, 0,0);
    vecs[2]  = mk(0,1,1, 3,4, 9,8,    1,0,0,0, 0, 1,0);
    vecs[3]  = mk(0,0,1, 3,4, 9,8,    0,1,1,0, 7, 1,1);
    vecs[4]  = mk(0,0,1, 0,0, 15,15,  0,1,1,1, 1, 1,2);
    vecs[5]  = mk(0,0,0, 0,0, 15,15,  0,0,1,1, 14,1,2);
    vecs[6]  = mk(0,0,0, 0,0, 0,0,    0,0,0,0, 14,1,2);
    vecs[7]  = mk(1,0,0, 0,0, 0,0,    0,0,0,0, 0, 0,0);
    vecs[8]  = mk(0,1,1, 1,1, 2,2,    1,0,0,0, 0, 1,0);
    vecs[9]  = mk(0,1,1, 1,1, 2,2,    0,1,1,0, 2, 1,1);
    vecs[10] = mk(0,1,1, 1,1, 2,2,    1,0,1,1, 4, 2,1);
    vecs[11] = mk(0,1,1, 1,1, 2,2,    0,1,1,0, 2, 2,2);
    vecs[12] = mk(0,1,1, 1,1, 2,2,    1,0,1,1, 4, 3,2);
    vecs[13] = mk(0,1,1, 1,1, 2,2,    0,1,1,0, 2, 3,3);
    vecs[14] = mk(0,0,0, 0,0, 0,0,    0,0,1,1, 4, 3,3);
    vecs[15] = mk(0,0,0, 0,0, 0,0,    0,0,0,0, 4, 3,3);
    vecs[16] = mk(0,1,0, 5,6, 0,0,    1,0,0,0, 4, 4,3);
    vecs[17] = mk(1,0,0, 5,6, 0,0,    0,0,0,0, 0, 0,0);
    vecs[18] = mk(0,0,0, 0,0, 0,0,    0,0,0,0, 0, 0,0);
    vecs[19] = mk(0,0,0, 0,0, 0,0,    0,0,0,0, 0, 0,0);
    vecs[20] = mk(0,1,0, 3,4, 0,0,    1,0,0,0, 0, 1,0);
    vecs[21] = mk(0,0,0, 3,4, 0,0,    0,0,1,0, 7, 1,0);
    vecs[22] = mk(0,0,1, 0,0, 9,8,    0,1,0,0, 7, 1,1);
    vecs[23] = mk(0,0,0, 0,0, 9,8,    0,0,1,1, 1, 1,1);

    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].rst, vecs[i].req0, vecs[i].req1,
            vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
      @(negedge clk);
      chk($sformatf("v%0d ack0", i), int'(rr_ack0), int'(vecs[i].e_ack0));
      chk($sformatf("v%0d ack1", i), int'(rr_ack1), int'(vecs[i].e_ack1));
      chk($sformatf("v%0d res_valid", i), int'(rr_rv), int'(vecs[i].e_rv));
      if (vecs[i].e_rv)
        chk($sformatf("v%0d res_id", i), int'(rr_rid), int'(vecs[i].e_rid));
      chk($sformatf("v%0d S_bus", i), int'(rr_s), int'(vecs[i].e_s));
      chk($sformatf("v%0d gnt_cnt0", i), int'(rr_g0), int'(vecs[i].e_g0));
      chk($sformatf("v%0d gnt_cnt1", i), int'(rr_g1), int'(vecs[i].e_g1));
    end

    // Fixed priority: requester 0 always wins while it requests.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 4'd1, 4'd1, 4'd2, 4'd2);
      @(negedge clk);
      chk($sformatf("fp%0d ack0", i), int'(fp_ack0), 1);
      chk($sformatf("fp%0d ack1", i), int'(fp_ack1), 0);
    end
    drive(1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 4'd2, 4'd2);
    @(negedge clk);
    chk("fp drop ack1", int'(fp_ack1), 1);
    chk("fp drop ack0", int'(fp_ack0), 0);
    chk("fp drop res_id", int'(fp_rid), 0);
    chk("fp drop S_bus", int'(fp_s), 2);
    chk("fp gnt_cnt0", int'(fp_g0), 4);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    chk("fp last res_valid", int'(fp_rv), 1);
    chk("fp last res_id", int'(fp_rid), 1);
    chk("fp last S_bus", int'(fp_s), 4);
    chk("fp gnt_cnt1", int'(fp_g1), 1);

    // Saturation: hold req0 for 300 edges on the round-robin instance.
    drive(1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 4'd1, 4'd2, 4'd0, 4'd0);
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (i == 254) chk("sat gnt_cnt0 at 254", int'(rr_g0), 254);
      if (i == 255) chk("sat gnt_cnt0 at 255", int'(rr_g0), 255);
    end
    chk("sat gnt_cnt0 final", int'(rr_g0), 255);
    chk("sat gnt_cnt1 final", int'(rr_g1), 0);
    chk("sat res_valid", int'(rr_rv), 1);
    chk("sat S_bus", int'(rr_s), 3);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
